// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port, fully registered 32-word data memory.
// Round-robin or fixed-priority grant with optional lock, plus a 2-stage response tracker.
module data_mem_arbiter #(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned MEM_AW     = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_lock,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_done,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_lock,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_done,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout
);

   localparam int unsigned DW  = 32;
   localparam int unsigned AHI = MEM_AW + 2;

   typedef struct packed {
      logic valid;
      logic id;
      logic we;
      logic err;
   } rsp_t;

   logic          last_id_q, last_id_d;
   logic          lock_v_q, lock_v_d;
   logic          lock_id_q, lock_id_d;
   logic          hand_v_q, hand_v_d;
   logic          hand_id_q, hand_id_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   rsp_t          s1_q, s1_d;
   rsp_t          s2_q;

   logic          g0_c, g1_c, win_c, gnt_any_c, gnt_id_c;
   logic          sel_we_c, sel_lock_c, sel_err_c, owner_req_c;
   logic [DW-1:0] sel_addr_c, sel_wdata_c;

   // Arbitration: lock owner first, then a one-shot handoff after a lock release, then policy.
   always_comb begin
      g0_c  = 1'b0;
      g1_c  = 1'b0;
      win_c = 1'b0;
      if (!rst) begin
         if (lock_v_q) begin
            if (lock_id_q) g1_c = p1_req;
            else           g0_c = p0_req;
         end else if (p0_req && p1_req) begin
            if (hand_v_q)        win_c = hand_id_q;
            else if (FIXED_PRIO) win_c = 1'b0;
            else                 win_c = ~last_id_q;
            g0_c = ~win_c;
            g1_c = win_c;
         end else begin
            g0_c = p0_req;
            g1_c = p1_req;
         end
      end
   end

   assign gnt_any_c   = g0_c | g1_c;
   assign gnt_id_c    = g1_c;
   assign sel_we_c    = g1_c ? p1_we    : p0_we;
   assign sel_lock_c  = g1_c ? p1_lock  : p0_lock;
   assign sel_addr_c  = g1_c ? p1_addr  : p0_addr;
   assign sel_wdata_c = g1_c ? p1_wdata : p0_wdata;
   assign sel_err_c   = |sel_addr_c[DW-1:AHI];
   assign owner_req_c = lock_id_q ? p1_req : p0_req;

   assign p0_gnt     = g0_c;
   assign p1_gnt     = g1_c;
   assign mem_we     = gnt_any_c & sel_we_c & ~sel_err_c;
   assign mem_addr   = gnt_any_c ? sel_addr_c  : addr_q;
   assign mem_datain = gnt_any_c ? sel_wdata_c : wdata_q;

   // Next-state for arbitration history, lock ownership and response stage 1.
   always_comb begin
      last_id_d = last_id_q;
      lock_v_d  = lock_v_q;
      lock_id_d = lock_id_q;
      hand_v_d  = 1'b0;
      hand_id_d = hand_id_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      s1_d      = '{valid: gnt_any_c, id: gnt_id_c, we: sel_we_c, err: sel_err_c};
      if (gnt_any_c) begin
         last_id_d = gnt_id_c;
         addr_d    = sel_addr_c;
         wdata_d   = sel_wdata_c;
      end
      if (lock_v_q) begin
         if (!owner_req_c) begin
            lock_v_d = 1'b0;
         end else if (gnt_any_c && !sel_lock_c) begin
            lock_v_d  = 1'b0;
            hand_v_d  = 1'b1;
            hand_id_d = ~lock_id_q;
         end
      end else if (gnt_any_c && sel_lock_c) begin
         lock_v_d  = 1'b1;
         lock_id_d = gnt_id_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_id_q <= 1'b1;
         lock_v_q  <= 1'b0;
         lock_id_q <= 1'b0;
         hand_v_q  <= 1'b0;
         hand_id_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
      end else begin
         last_id_q <= last_id_d;
         lock_v_q  <= lock_v_d;
         lock_id_q <= lock_id_d;
         hand_v_q  <= hand_v_d;
         hand_id_q <= hand_id_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         s1_q      <= s1_d;
         s2_q      <= s1_q;
      end
   end

   // Stage 2 lines up with the memory's registered read data.
   assign p0_done  = s2_q.valid & ~s2_q.id;
   assign p1_done  = s2_q.valid &  s2_q.id;
   assign p0_err   = p0_done & s2_q.err;
   assign p1_err   = p1_done & s2_q.err;
   assign p0_rdata = (p0_done && !s2_q.we && !s2_q.err) ? mem_dataout : '0;
   assign p1_rdata = (p1_done && !s2_q.we && !s2_q.err) ? mem_dataout : '0;

endmodule
